// File: rtl/lbm_step_sequencer_pkg.sv
// lbm_step_sequencer_pkg: shared widths, lattice defaults, FSM and phase encodings.
package lbm_step_sequencer_pkg;
  localparam int ADDRESS_WIDTH = 12;
  localparam int NX_DEF = 50;
  localparam int NY_DEF = 50;
  typedef enum logic [2:0] {S_IDLE, S_COLLIDE, S_DRAIN, S_STREAM, S_SWAP, S_DONE} state_t;
  typedef enum logic [1:0] {PH_IDLE = 2'd0, PH_COLLIDE = 2'd1, PH_STREAM = 2'd2, PH_DONE = 2'd3} phase_t;
  function automatic phase_t phase_of(input state_t s);
    return s == S_IDLE ? PH_IDLE :
           (s == S_COLLIDE || s == S_DRAIN) ? PH_COLLIDE :
           (s == S_STREAM || s == S_SWAP) ? PH_STREAM : PH_DONE;
  endfunction
endpackage

// File: rtl/lbm_step_sequencer_lattice_scan_counter.sv
// lattice_scan_counter: row-major x/y walk over the lattice with an incrementally built
// linear address and registered boundary flags {n, s, e, w} that track the current cell.
module lattice_scan_counter
  import lbm_step_sequencer_pkg::*;
#(
  parameter int NX = NX_DEF,
  parameter int NY = NY_DEF,
  parameter int AW = ADDRESS_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv_i,
  input  logic          clr_i,
  output logic [AW-1:0] x_o,
  output logic [AW-1:0] y_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o,
  output logic [3:0]    edge_o
);
  localparam logic [AW-1:0] XL = AW'(NX - 1);
  localparam logic [AW-1:0] YL = AW'(NY - 1);
  localparam logic [3:0] EDGE0 = {1'b1, YL == '0, XL == '0, 1'b1};
  logic [AW-1:0] x_q, x_d, y_q, y_d, addr_q, addr_d;
  logic [3:0] edge_q, edge_d;
  logic wrap_x;
  always_comb begin
    wrap_x = x_q == XL;
    last_o = wrap_x && y_q == YL;
    x_d = (clr_i || (adv_i && wrap_x)) ? '0 : adv_i ? x_q + 1'b1 : x_q;
    y_d = (clr_i || (adv_i && last_o)) ? '0 : (adv_i && wrap_x) ? y_q + 1'b1 : y_q;
    addr_d = (clr_i || (adv_i && last_o)) ? '0 : adv_i ? addr_q + 1'b1 : addr_q;
    edge_d = {y_d == '0, y_d == YL, x_d == XL, x_d == '0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      addr_q <= '0;
      edge_q <= EDGE0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      addr_q <= addr_d;
      edge_q <= edge_d;
    end
  end
  assign x_o = x_q;
  assign y_o = y_q;
  assign addr_o = addr_q;
  assign edge_o = edge_q;
endmodule

// File: rtl/lbm_step_sequencer.sv
// lbm_step_sequencer: runs whole LBM timesteps (collide sweep, drain, stream sweep, bank swap)
// over an NX x NY lattice for a programmed number of steps.
module lbm_step_sequencer
  import lbm_step_sequencer_pkg::*;
#(
  parameter int NX = NX_DEF,
  parameter int NY = NY_DEF,
  parameter int AW = ADDRESS_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [31:0]   step,
  input  logic          col_ready,
  input  logic          col_res_valid,
  output logic          col_valid,
  output logic [AW-1:0] col_addr,
  output logic          str_rd_en,
  output logic [AW-1:0] str_rd_addr,
  output logic          str_wr_en,
  output logic [AW-1:0] str_wr_addr,
  output logic          edge_n,
  output logic          edge_s,
  output logic          edge_e,
  output logic          edge_w,
  output logic          buf_sel,
  output logic [1:0]    phase,
  output logic [31:0]   steps_done,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam logic [AW:0] TOT = (AW + 1)'(NX * NY);
  state_t state_q, state_d;
  logic [31:0] step_q, step_d, steps_done_q, steps_done_d;
  logic [AW:0] res_q, res_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic buf_sel_q, buf_sel_d, err_q, err_d, rd_done_q, rd_done_d, wr_en_q;
  logic start_acc, swap_go, in_col, col_last, str_last;
  logic [3:0] str_edge, unused_col_edge;
  logic [AW-1:0] unused_col_x, unused_col_y, unused_str_x, unused_str_y;
  lattice_scan_counter #(.NX(NX), .NY(NY), .AW(AW)) u_col (
    .clk(clk), .rst_n(rst_n), .adv_i(col_valid && col_ready), .clr_i(start_acc),
    .x_o(unused_col_x), .y_o(unused_col_y), .addr_o(col_addr), .last_o(col_last),
    .edge_o(unused_col_edge)
  );
  lattice_scan_counter #(.NX(NX), .NY(NY), .AW(AW)) u_str (
    .clk(clk), .rst_n(rst_n), .adv_i(str_rd_en), .clr_i(start_acc),
    .x_o(unused_str_x), .y_o(unused_str_y), .addr_o(str_rd_addr), .last_o(str_last),
    .edge_o(str_edge)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_acc) state_d = step == 32'd0 ? S_DONE : S_COLLIDE;
      S_COLLIDE: if (col_valid && col_ready && col_last) state_d = S_DRAIN;
      S_DRAIN: if (en && res_q == TOT) state_d = S_STREAM;
      S_STREAM: if (en && rd_done_q) state_d = S_SWAP;
      S_SWAP: if (en) state_d = steps_done_q + 32'd1 == step_q ? S_DONE : S_COLLIDE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    col_valid = en && state_q == S_COLLIDE;
    str_rd_en = en && state_q == S_STREAM && !rd_done_q;
    {edge_n, edge_s, edge_e, edge_w} = state_q == S_STREAM ? str_edge : 4'b0;
    phase = phase_of(state_q);
    busy = !(state_q == S_IDLE || state_q == S_DONE);
    done = state_q == S_DONE;
  end
  // Results are counted even while en is low so a frozen sequencer never loses collider writebacks.
  always_comb begin
    start_acc = en && start && !busy;
    swap_go = en && state_q == S_SWAP;
    in_col = state_q == S_COLLIDE || state_q == S_DRAIN;
    step_d = start_acc ? step : step_q;
    steps_done_d = start_acc ? '0 : swap_go ? steps_done_q + 32'd1 : steps_done_q;
    buf_sel_d = buf_sel_q ^ swap_go;
    res_d = (start_acc || swap_go) ? '0 : (col_res_valid && in_col && res_q != TOT) ? res_q + 1'b1 : res_q;
    err_d = (err_q && !start_acc) || (col_res_valid && (!in_col || res_q == TOT));
    rd_done_d = (start_acc || swap_go) ? 1'b0 : (str_rd_en && str_last) ? 1'b1 : rd_done_q;
    wr_addr_d = str_rd_en ? str_rd_addr : wr_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      steps_done_q <= '0;
      buf_sel_q <= 1'b0;
      res_q <= '0;
      err_q <= 1'b0;
      rd_done_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      step_q <= step_d;
      steps_done_q <= steps_done_d;
      buf_sel_q <= buf_sel_d;
      res_q <= res_d;
      err_q <= err_d;
      rd_done_q <= rd_done_d;
      wr_en_q <= str_rd_en;
      wr_addr_q <= wr_addr_d;
    end
  end
  assign steps_done = steps_done_q;
  assign buf_sel = buf_sel_q;
  assign err = err_q;
  assign str_wr_en = wr_en_q;
  assign str_wr_addr = wr_addr_q;
endmodule

// File: tb/tb_lbm_step_sequencer.sv
// tb_lbm_step_sequencer: scoreboard bench; expected collide/read/write streams are queued at run start
// and a monitor pops them as the sequencer presents each transaction.
module tb_lbm_step_sequencer;
  logic clk, rst_n, en, start, col_ready, col_res_valid;
  logic [31:0] step;
  logic col_valid, str_rd_en, str_wr_en, edge_n, edge_s, edge_e, edge_w, buf_sel, busy, done, err;
  logic [11:0] col_addr, str_rd_addr, str_wr_addr;
  logic [1:0] phase;
  logic [31:0] steps_done;
  logic inj_res = 1'b0;
  logic rnd_ready = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_col[$];
  logic [15:0] exp_rd[$];
  logic [11:0] exp_wr[$];

  lbm_step_sequencer #(.NX(50), .NY(50), .AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .step(step),
    .col_ready(col_ready), .col_res_valid(col_res_valid),
    .col_valid(col_valid), .col_addr(col_addr),
    .str_rd_en(str_rd_en), .str_rd_addr(str_rd_addr),
    .str_wr_en(str_wr_en), .str_wr_addr(str_wr_addr),
    .edge_n(edge_n), .edge_s(edge_s), .edge_e(edge_e), .edge_w(edge_w),
    .buf_sel(buf_sel), .phase(phase), .steps_done(steps_done),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic void push_run(input int n);
    for (int s = 0; s < n; s++)
      for (int i = 0; i < 2500; i++) begin
        int x, y;
        logic [11:0] a;
        x = i % 50;
        y = i / 50;
        a = 12'(i);
        exp_col.push_back(a);
        exp_rd.push_back({y == 0, y == 49, x == 49, x == 0, a});
        exp_wr.push_back(a);
      end
  endfunction

  task automatic go(input int n);
    tick;
    start = 1;
    step = n;
    tick;
    start = 0;
  endtask

  task automatic wait_done;
    int c = 0;
    while (!done && c < 30000) begin
      tick;
      c++;
    end
    chk("done_reached", done, 1);
  endtask

  task automatic wait_stream;
    int c = 0;
    while (phase != 2'd2 && c < 30000) begin
      tick;
      c++;
    end
    chk("stream_reached", phase, 2);
  endtask

  task automatic reset_checks;
    chk("reset_ctl", {col_valid, str_rd_en, str_wr_en, edge_n, edge_s, edge_e, edge_w,
                      buf_sel, phase, busy, done, err}, 0);
    chk("reset_addr", {col_addr, str_rd_addr, str_wr_addr}, 0);
    chk("reset_steps", steps_done, 0);
  endtask

  task automatic end_checks(input logic b, input int s, input logic e);
    chk("buf_sel", buf_sel, b);
    chk("steps_done", steps_done, s);
    chk("err", err, e);
    chk("phase_done", phase, 3);
    chk("col_all_seen", exp_col.size(), 0);
    chk("rd_all_seen", exp_rd.size(), 0);
    chk("wr_all_seen", exp_wr.size(), 0);
  endtask

  // Collider model: accepted cells come back as results three cycles later.
  initial begin
    logic fire, p1, p2;
    fire = 0; p1 = 0; p2 = 0;
    col_ready = 1;
    col_res_valid = 0;
    forever begin
      @(posedge clk);
      #1;
      col_res_valid = p2 | inj_res;
      p2 = p1;
      p1 = fire;
      col_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #7;
      fire = col_valid && col_ready;
    end
  end

  initial begin
    logic rd_prev;
    rd_prev = 0;
    forever begin
      @(posedge clk);
      #8;
      if (rst_n) begin
        if (col_valid && col_ready) begin
          chk("col_expected", exp_col.size() != 0, 1);
          if (exp_col.size() != 0) chk("col_addr", col_addr, exp_col.pop_front());
        end
        if (str_rd_en) begin
          chk("rd_expected", exp_rd.size() != 0, 1);
          if (exp_rd.size() != 0)
            chk("rd_addr_edges", {edge_n, edge_s, edge_e, edge_w, str_rd_addr}, exp_rd.pop_front());
        end
        if (str_wr_en) begin
          chk("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) chk("wr_addr", str_wr_addr, exp_wr.pop_front());
        end
        chk("wr_follows_rd", str_wr_en, rd_prev);
      end
      rd_prev = rst_n && str_rd_en;
    end
  end

  initial begin
    logic [11:0] held;
    rst_n = 0; en = 1; start = 0; step = 0;
    repeat (3) tick;
    #1;
    reset_checks();
    rst_n = 1;
    go(0);
    #1;
    chk("step0_done", {done, phase}, {1'b1, 2'd3});
    push_run(1);
    go(1);
    wait_done();
    end_checks(1'b1, 1, 1'b0);
    push_run(2);
    go(2);
    wait_stream();
    repeat (50) tick;
    rst_n = 0;
    #1;
    reset_checks();
    exp_col.delete();
    exp_rd.delete();
    exp_wr.delete();
    repeat (2) tick;
    rst_n = 1;
    tick;
    reset_checks();
    push_run(3);
    go(3);
    repeat (10) tick;
    start = 1;
    step = 0;
    tick;
    start = 0;
    #1;
    chk("start_ignored", {phase, busy, done}, {2'd1, 1'b1, 1'b0});
    wait_done();
    end_checks(1'b1, 3, 1'b0);
    rnd_ready = 1;
    push_run(1);
    go(1);
    wait_stream();
    repeat (100) tick;
    inj_res = 1;
    tick;
    inj_res = 0;
    en = 0;
    #1;
    chk("freeze_rd_off", str_rd_en, 0);
    chk("freeze_pending_wr", str_wr_en, 1);
    held = str_rd_addr;
    repeat (5) begin
      tick;
      chk("freeze_hold", {phase, str_rd_addr}, {2'd2, held});
      chk("freeze_no_wr", str_wr_en, 0);
    end
    chk("err_set", err, 1);
    en = 1;
    wait_done();
    end_checks(1'b0, 1, 1'b1);
    rnd_ready = 0;
    go(0);
    #1;
    chk("err_cleared", {done, err}, 2'b10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
